// File: rtl/qdec_pkg.sv
// -----------------------------------------------------------------------------
// qdec_pkg
//   Shared types and helpers for the quadrature step decoder.
//   - qdec_state_t : decoder FSM states (INIT plus one state per phase code)
//   - DIR_UP/DIR_DN: direction output encodings
//   - phase_to_state / fwd_next : map a 2-bit phase {a,b} onto the Gray-code
//     cycle P00 -> P01 -> P11 -> P10 -> P00 (forward rotation)
// -----------------------------------------------------------------------------
package qdec_pkg;

    typedef enum logic [2:0] {
        INIT = 3'd0,
        P00  = 3'd1,
        P01  = 3'd2,
        P11  = 3'd3,
        P10  = 3'd4
    } qdec_state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    function automatic qdec_state_t phase_to_state(input logic [1:0] p);
        case (p)
            2'b00:   return P00;
            2'b01:   return P01;
            2'b11:   return P11;
            default: return P10;
        endcase
    endfunction

    // Successor of a phase state in the forward rotation sense.
    function automatic qdec_state_t fwd_next(input qdec_state_t s);
        case (s)
            P00:     return P01;
            P01:     return P11;
            P11:     return P10;
            P10:     return P00;
            default: return INIT;
        endcase
    endfunction

endpackage

// File: rtl/qdec_chan_filter.sv
// -----------------------------------------------------------------------------
// qdec_chan_filter
//   One phase channel: SYNC_STAGES-deep synchronizer for an asynchronous pin,
//   optionally followed by a glitch filter (build with QDEC_FILTER_EN defined).
//   With the filter, the output only follows the synchronized input after it
//   has shown the new value for FILTER_LEN consecutive cycles.
// Ports
//   clk    in  rising-edge clock
//   rst    in  async reset, active-high (clears sync chain and filter)
//   raw    in  asynchronous phase pin
//   bypass in  load the filter output straight from the synchronizer
//              (used while the decoder is priming after reset)
//   filt   out synchronized (and filtered) phase bit
// -----------------------------------------------------------------------------
module qdec_chan_filter
    import qdec_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic bypass,
    output logic filt
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef QDEC_FILTER_EN
    localparam int CNT_W = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

    logic [CNT_W-1:0] stable_cnt;
    logic             filt_q;

    // stable_cnt counts consecutive cycles where the synchronized bit differs
    // from the filtered bit; any return to the old value restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_cnt <= '0;
            filt_q     <= 1'b0;
        end else if (bypass) begin
            stable_cnt <= '0;
            filt_q     <= sync_out;
        end else if (sync_out == filt_q) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CNT_W'(FILTER_LEN - 1)) begin
            stable_cnt <= '0;
            filt_q     <= sync_out;
        end else begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end

    assign filt = filt_q;
`else
    localparam int unused_filter_len = FILTER_LEN;
    logic unused_bypass;
    assign unused_bypass = bypass;
    assign filt          = sync_out;
`endif

endmodule

// File: rtl/quad_step_decoder.sv
// -----------------------------------------------------------------------------
// quad_step_decoder
//   Quadrature front end for counterUpDown. Synchronizes (and, with
//   QDEC_FILTER_EN defined, glitch-filters) the two phase pins, then tracks
//   the Gray-code phase with an FSM: one enable strobe per legal edge, with
//   direction giving the rotation sense. Double-bit jumps set a sticky error
//   flag and bump a saturating counter.
// Parameters
//   SYNC_STAGES  synchronizer depth per phase (>= 2)
//   FILTER_LEN   stable cycles needed by the glitch filter (QDEC_FILTER_EN)
//   ERR_CNT_W    width of the illegal-transition counter
// Ports
//   clk        in   rising-edge clock
//   rst        in   async reset, active-high
//   qa, qb     in   asynchronous phase A / phase B
//   clear_err  in   sync clear of error and err_cnt (a same-cycle jump wins)
//   enable     out  one-cycle step strobe
//   direction  out  1 = up (forward order), 0 = down; held between steps
//   error      out  sticky illegal-transition flag
//   err_cnt    out  saturating illegal-transition count
// -----------------------------------------------------------------------------
module quad_step_decoder
    import qdec_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int ERR_CNT_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 qa,
    input  logic                 qb,
    input  logic                 clear_err,
    output logic                 enable,
    output logic                 direction,
    output logic                 error,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    // The synchronizer flops come out of reset at 0, so the phase seen by the
    // FSM is only meaningful once the pin values have shifted through. INIT
    // waits that many cycles before loading the phase, otherwise a reset taken
    // at phase 11 would look like a 00->11 jump right after release. With the
    // filter present it is bypassed during INIT and needs one extra cycle.
`ifdef QDEC_FILTER_EN
    localparam int PRIME = SYNC_STAGES + 1;
`else
    localparam int PRIME = SYNC_STAGES;
`endif
    localparam int PRIME_W = $clog2(PRIME + 1);

    logic        qa_f, qb_f;
    logic [1:0]  p;
    logic        priming;

    qdec_state_t          state_q, state_d;
    qdec_state_t          p_state;
    logic [PRIME_W-1:0]   prime_q, prime_d;
    logic                 enable_q, enable_d;
    logic                 dir_q, dir_d;
    logic                 error_q, error_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 illegal;

    assign priming = (state_q == INIT);

    qdec_chan_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_chan_a (
        .clk    (clk),
        .rst    (rst),
        .raw    (qa),
        .bypass (priming),
        .filt   (qa_f)
    );

    qdec_chan_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_chan_b (
        .clk    (clk),
        .rst    (rst),
        .raw    (qb),
        .bypass (priming),
        .filt   (qb_f)
    );

    assign p       = {qa_f, qb_f};
    assign p_state = phase_to_state(p);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= INIT;
            prime_q   <= '0;
            enable_q  <= 1'b0;
            dir_q     <= 1'b0;
            error_q   <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            prime_q   <= prime_d;
            enable_q  <= enable_d;
            dir_q     <= dir_d;
            error_q   <= error_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        prime_d   = prime_q;
        enable_d  = 1'b0;
        dir_d     = dir_q;
        error_d   = error_q;
        err_cnt_d = err_cnt_q;
        illegal   = 1'b0;

        case (state_q)
            INIT: begin
                if (prime_q == PRIME_W'(PRIME)) begin
                    state_d = p_state;
                end else begin
                    prime_d = prime_q + 1'b1;
                end
            end
            default: begin
                if (p_state != state_q) begin
                    if (p_state == fwd_next(state_q)) begin
                        enable_d = 1'b1;
                        dir_d    = DIR_UP;
                    end else if (state_q == fwd_next(p_state)) begin
                        enable_d = 1'b1;
                        dir_d    = DIR_DN;
                    end else begin
                        illegal = 1'b1;
                    end
                    // An illegal jump also resyncs to the new phase.
                    state_d = p_state;
                end
            end
        endcase

        // Clear first, then count: a jump in the same cycle leaves error=1,
        // err_cnt=1.
        if (clear_err) begin
            error_d   = 1'b0;
            err_cnt_d = '0;
        end
        if (illegal) begin
            error_d = 1'b1;
            if (err_cnt_d != '1) begin
                err_cnt_d = err_cnt_d + 1'b1;
            end
        end
    end

    assign enable    = enable_q;
    assign direction = dir_q;
    assign error     = error_q;
    assign err_cnt   = err_cnt_q;

endmodule
